// File: rtl/mod_enc_round_ctrl.sv
// AES-256 encryption round sequencer.
// Walks the encryption datapath through the initial key addition, NR-1 full rounds
// and the final round. For each step it drives the round-key index, the addRoundKey
// operand select, the mixColumns enable and the state-register write enable.
`timescale 1ns/1ps

module mod_enc_round_ctrl #(
    parameter int unsigned NR  = 14,
    parameter int unsigned RKW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_ready,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [RKW-1:0] rk_idx,
    output logic           sel_in,
    output logic           en_mix,
    output logic           state_we,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           err
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRound,
        StFinal,
        StDone
    } state_e;

    // Last full round; the cycle after it is the final round.
    localparam logic [RKW-1:0] LastRound = RKW'(NR - 1);
    localparam logic [RKW-1:0] FinalIdx  = RKW'(NR);

    state_e         state_q, state_d;
    logic [RKW-1:0] cnt_q, cnt_d;
    logic           err_q, err_d;

    // New blocks are taken only when idle, keys are valid and reset is not asserted.
    assign in_ready = (state_q == StIdle) & key_ready & ~rst;

    // Next-state, round counter and abort detection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (in_valid && in_ready) begin
                    state_d = StInit;
                end
            end
            StInit: begin
                if (!key_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    state_d = StRound;
                    cnt_d   = RKW'(1);
                end
            end
            StRound: begin
                if (!key_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    // Counter ends at NR on entry to the final round, so it never wraps.
                    cnt_d = cnt_q + RKW'(1);
                    if (cnt_q == LastRound) begin
                        state_d = StFinal;
                    end
                end
            end
            StFinal: begin
                if (!key_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Key loss here does not abort: the ciphertext is already complete.
                if (out_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and error-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Datapath controls decoded from the registered state and counter.
    always_comb begin
        rk_idx    = '0;
        sel_in    = 1'b0;
        en_mix    = 1'b0;
        state_we  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                rk_idx = '0;
            end
            StInit: begin
                rk_idx   = '0;
                sel_in   = 1'b1;
                state_we = 1'b1;
                busy     = 1'b1;
            end
            StRound: begin
                rk_idx   = cnt_q;
                en_mix   = 1'b1;
                state_we = 1'b1;
                busy     = 1'b1;
            end
            StFinal: begin
                rk_idx   = FinalIdx;
                state_we = 1'b1;
                busy     = 1'b1;
            end
            StDone: begin
                rk_idx    = FinalIdx;
                out_valid = 1'b1;
            end
            default: begin
                rk_idx = '0;
            end
        endcase
    end

    assign err = err_q;

endmodule
